// File: rtl/sprite_pkg.sv
// Shared sprite definitions: default geometry, transparent palette index and
// the sprite RAM address type, used by the fetch block and the sprite RAM.
package sprite_pkg;
  localparam int SPR_W_DEF      = 20;
  localparam int SPR_H_DEF      = 20;
  localparam int NUM_FRAMES_DEF = 2;
  localparam int ADDR_W         = 19;

  typedef logic [ADDR_W-1:0] spr_addr_t;
  typedef logic [2:0]        pal_idx_t;

  localparam pal_idx_t TRANSPARENT_DEF = 3'h0;
endpackage

// File: rtl/sprite_anim_ctr.sv
// Animation step counter: counts frame_start pulses while enabled and
// advances frame_sel every ANIM_DIV pulses, wrapping at NUM_FRAMES.
module sprite_anim_ctr #(
  parameter int ANIM_DIV   = 8,
  parameter int NUM_FRAMES = 2,
  parameter int FS_W       = 1
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            frame_start,
  input  logic            anim_en,
  output logic [FS_W-1:0] frame_sel
);
  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt       <= '0;
      frame_sel <= '0;
    end else if (frame_start && anim_en) begin
      if (cnt == CW'(ANIM_DIV-1)) begin
        cnt       <= '0;
        frame_sel <= (frame_sel == FS_W'(NUM_FRAMES-1)) ? '0 : frame_sel + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_fetch.sv
// Two-stage sprite pixel fetch: hit test and RAM address on stage 1,
// RAM data capture and opacity decision on stage 2.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int       SPR_W       = SPR_W_DEF,
  parameter int       SPR_H       = SPR_H_DEF,
  parameter int       NUM_FRAMES  = NUM_FRAMES_DEF,
  parameter int       ANIM_DIV    = 8,
  parameter pal_idx_t TRANSPARENT = TRANSPARENT_DEF,
  localparam int      FS_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            frame_start,
  input  logic            pix_valid,
  input  logic [9:0]      DrawX,
  input  logic [9:0]      DrawY,
  input  logic [9:0]      SpriteX,
  input  logic [9:0]      SpriteY,
  input  logic            flip,
  input  logic            anim_en,
  input  pal_idx_t        ram_data,
  output spr_addr_t       read_address,
  output pal_idx_t        pixel_index,
  output logic            pixel_on,
  output logic            out_valid,
  output logic [FS_W-1:0] frame_sel
);
  localparam spr_addr_t FRAME_PIX = spr_addr_t'(SPR_W * SPR_H);

  logic [9:0] sx, sy;
  logic       sflip;
  logic       hit;
  logic [9:0] col, col_raw, row;
  spr_addr_t  addr_next;
  logic       s1_valid, s1_hit;

  // Shadow position/flip, so the sprite cannot tear within a frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx    <= '0;
      sy    <= '0;
      sflip <= 1'b0;
    end else if (frame_start) begin
      sx    <= SpriteX;
      sy    <= SpriteY;
      sflip <= flip;
    end
  end

  sprite_anim_ctr #(
    .ANIM_DIV  (ANIM_DIV),
    .NUM_FRAMES(NUM_FRAMES),
    .FS_W      (FS_W)
  ) u_anim (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_start(frame_start),
    .anim_en    (anim_en),
    .frame_sel  (frame_sel)
  );

  // 11-bit compare keeps sprites near the right/bottom edge from wrapping.
  always_comb begin
    hit = ({1'b0, DrawX} >= {1'b0, sx}) &&
          ({1'b0, DrawX} <  ({1'b0, sx} + 11'(SPR_W))) &&
          ({1'b0, DrawY} >= {1'b0, sy}) &&
          ({1'b0, DrawY} <  ({1'b0, sy} + 11'(SPR_H)));
    col_raw   = DrawX - sx;
    col       = sflip ? (10'(SPR_W-1) - col_raw) : col_raw;
    row       = DrawY - sy;
    addr_next = spr_addr_t'(frame_sel) * FRAME_PIX
              + spr_addr_t'(row) * spr_addr_t'(SPR_W)
              + spr_addr_t'(col);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address <= '0;
      s1_valid     <= 1'b0;
      s1_hit       <= 1'b0;
      pixel_index  <= '0;
      pixel_on     <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      read_address <= (hit && pix_valid) ? addr_next : '0;
      s1_valid     <= pix_valid;
      s1_hit       <= hit;
      // Stage 2 is held directly in the output registers.
      out_valid    <= s1_valid;
      pixel_on     <= s1_valid && s1_hit && (ram_data != TRANSPARENT);
      pixel_index  <= s1_hit ? ram_data : '0;
    end
  end
endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch with a combinational-read sprite RAM model.
module tb_sprite_fetch;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0, pix_valid = 1'b0, flip = 1'b0, anim_en = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
  logic [2:0]  ram_data;
  logic [18:0] read_address;
  logic [2:0]  pixel_index;
  logic        pixel_on, out_valid;
  logic [0:0]  frame_sel;
  logic [2:0]  mem [0:1023];
  int          tests = 0, fails = 0;

  always #5 Clk = ~Clk;

  always_comb ram_data = (read_address < 19'd1024) ? mem[read_address[9:0]] : 3'd7;

  sprite_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
    .flip(flip), .anim_en(anim_en), .ram_data(ram_data),
    .read_address(read_address), .pixel_index(pixel_index), .pixel_on(pixel_on),
    .out_valid(out_valid), .frame_sel(frame_sel)
  );

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic pulse();
    frame_start = 1'b1; step(); frame_start = 1'b0;
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1'b1;
  endtask

  task automatic test_reset();
    step(); step();
    tests++; if (read_address !== 19'd0) begin fails++; $display("FAIL reset_addr got %0d exp 0", read_address); end
    tests++; if ({pixel_on, out_valid, pixel_index} !== 5'd0) begin fails++; $display("FAIL reset_out got %b exp 0", {pixel_on, out_valid, pixel_index}); end
    tests++; if (frame_sel !== 1'b0) begin fails++; $display("FAIL reset_fsel got %0d exp 0", frame_sel); end
    #3 Reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    SpriteX = 10'd100; SpriteY = 10'd50; flip = 1'b0; pulse();
    pix(105, 52); step(); pix_valid = 1'b0;
    tests++; if (read_address !== 19'd45) begin fails++; $display("FAIL basic_addr got %0d exp 45", read_address); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_lat got %0d exp 0", out_valid); end
    step();
    tests++; if ({out_valid, pixel_on, pixel_index} !== {1'b1, 1'b1, 3'd5}) begin fails++; $display("FAIL basic_out got %b exp 115", {out_valid, pixel_on, pixel_index}); end
  endtask

  task automatic test_flip();
    flip = 1'b1; pulse(); flip = 1'b0;
    pix(105, 52); step(); pix_valid = 1'b0;
    tests++; if (read_address !== 19'd54) begin fails++; $display("FAIL flip_addr got %0d exp 54", read_address); end
    step();
    tests++; if ({out_valid, pixel_on, pixel_index} !== {1'b1, 1'b0, 3'd0}) begin fails++; $display("FAIL flip_transp got %b exp 100", {out_valid, pixel_on, pixel_index}); end
    pulse();  // restore unflipped shadow
  endtask

  task automatic test_back_to_back();
    pix(105, 52); step();
    pix(119, 52); step();
    tests++; if (read_address !== 19'd59) begin fails++; $display("FAIL b2b_addr got %0d exp 59", read_address); end
    tests++; if ({out_valid, pixel_on, pixel_index} !== {1'b1, 1'b1, 3'd5}) begin fails++; $display("FAIL b2b_first got %b exp 115", {out_valid, pixel_on, pixel_index}); end
    pix(120, 52); step(); pix_valid = 1'b0;
    tests++; if (read_address !== 19'd0) begin fails++; $display("FAIL b2b_rightedge got %0d exp 0", read_address); end
    tests++; if ({out_valid, pixel_on, pixel_index} !== {1'b1, 1'b1, 3'd3}) begin fails++; $display("FAIL b2b_second got %b exp 113", {out_valid, pixel_on, pixel_index}); end
    step();
    tests++; if ({out_valid, pixel_on, pixel_index} !== {1'b1, 1'b0, 3'd0}) begin fails++; $display("FAIL b2b_miss got %b exp 100", {out_valid, pixel_on, pixel_index}); end
  endtask

  task automatic test_wrap();
    SpriteX = 10'd1015; pulse();
    pix(3, 52); step();
    tests++; if (read_address !== 19'd0) begin fails++; $display("FAIL wrap_addr got %0d exp 0", read_address); end
    pix(1020, 52); step(); pix_valid = 1'b0;
    tests++; if (read_address !== 19'd45) begin fails++; $display("FAIL wrap_hit got %0d exp 45", read_address); end
    tests++; if ({out_valid, pixel_on, pixel_index} !== {1'b1, 1'b0, 3'd0}) begin fails++; $display("FAIL wrap_out got %b exp 100", {out_valid, pixel_on, pixel_index}); end
  endtask

  task automatic test_shadow();
    SpriteX = 10'd100;
    pix(105, 52); step(); pix_valid = 1'b0;
    tests++; if (read_address !== 19'd0) begin fails++; $display("FAIL shadow_hold got %0d exp 0", read_address); end
    pulse();
    pix(105, 52); step(); pix_valid = 1'b0;
    tests++; if (read_address !== 19'd45) begin fails++; $display("FAIL shadow_new got %0d exp 45", read_address); end
  endtask

  task automatic test_anim();
    anim_en = 1'b0; pulse(); pulse();
    tests++; if (frame_sel !== 1'b0) begin fails++; $display("FAIL anim_hold got %0d exp 0", frame_sel); end
    anim_en = 1'b1;
    for (int i = 0; i < 7; i++) pulse();
    tests++; if (frame_sel !== 1'b0) begin fails++; $display("FAIL anim_7 got %0d exp 0", frame_sel); end
    // 8th pulse coincides with a pixel: old shadow and old frame apply
    SpriteX = 10'd0; SpriteY = 10'd0;
    pix(105, 52); pulse(); pix_valid = 1'b0;
    tests++; if (read_address !== 19'd45) begin fails++; $display("FAIL anim_coincide got %0d exp 45", read_address); end
    tests++; if (frame_sel !== 1'b1) begin fails++; $display("FAIL anim_8 got %0d exp 1", frame_sel); end
    anim_en = 1'b0; SpriteX = 10'd100; SpriteY = 10'd50; pulse();
    pix(100, 50); step(); pix_valid = 1'b0;
    tests++; if (read_address !== 19'd400) begin fails++; $display("FAIL anim_f1addr got %0d exp 400", read_address); end
    step();
    tests++; if ({pixel_on, pixel_index} !== {1'b1, 3'd6}) begin fails++; $display("FAIL anim_f1data got %b exp 1110", {pixel_on, pixel_index}); end
    anim_en = 1'b1;
    for (int i = 0; i < 8; i++) pulse();
    anim_en = 1'b0;
    tests++; if (frame_sel !== 1'b0) begin fails++; $display("FAIL anim_16 got %0d exp 0", frame_sel); end
  endtask

  task automatic test_midreset();
    anim_en = 1'b1;
    for (int i = 0; i < 8; i++) pulse();
    anim_en = 1'b0;
    tests++; if (frame_sel !== 1'b1) begin fails++; $display("FAIL mrst_pre got %0d exp 1", frame_sel); end
    pix(105, 52); step();
    pix(106, 52);
    #2 Reset_n = 1'b0; #1;
    tests++; if ({read_address, pixel_index, pixel_on, out_valid} !== 24'd0) begin fails++; $display("FAIL mrst_outs got %h exp 0", {read_address, pixel_index, pixel_on, out_valid}); end
    tests++; if (frame_sel !== 1'b0) begin fails++; $display("FAIL mrst_fsel got %0d exp 0", frame_sel); end
    step(); Reset_n = 1'b1; pix_valid = 1'b0;
    step(); step();
    tests++; if ({out_valid, pixel_on} !== 2'b00) begin fails++; $display("FAIL mrst_stale got %b exp 00", {out_valid, pixel_on}); end
    pix(5, 2); step(); pix_valid = 1'b0;
    tests++; if ({read_address, out_valid} !== {19'd45, 1'b0}) begin fails++; $display("FAIL mrst_shadow got %0d/%0d exp 45/0", read_address, out_valid); end
    step();
    tests++; if ({out_valid, pixel_on, pixel_index} !== {1'b1, 1'b1, 3'd5}) begin fails++; $display("FAIL mrst_first got %b exp 115", {out_valid, pixel_on, pixel_index}); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 3'd7;
    mem[45] = 3'd5; mem[54] = 3'd0; mem[59] = 3'd3; mem[400] = 3'd6;
    test_reset();
    test_basic();
    test_flip();
    test_back_to_back();
    test_wrap();
    test_shadow();
    test_anim();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
